// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the FSM state encoding, the default branch latency and counter widths.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam int BRANCH_LAT_DEF = 2;
  localparam int STALL_CNT_W    = 16;
  localparam int BR_CNT_W       = 3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Counts one per clock while en is high; cleared asynchronously by rst_n.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush/redirect controller for a 5-stage pipeline: handles load-use
// bubbles, multi-cycle branch resolution and data-memory wait states.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int BRANCH_LAT = BRANCH_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LoadUseHazD,
  input  logic        BranchD,
  input  logic        BranchTakenE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        RedirectF,
  output logic [1:0]  CtrlState,
  output logic [15:0] StallCount
);

  localparam logic [BR_CNT_W-1:0] BR_LOAD = BR_CNT_W'(BRANCH_LAT - 1);

  ctrl_state_t         state, state_nxt;
  ctrl_state_t         ret, ret_nxt;
  logic [BR_CNT_W-1:0] cnt, cnt_nxt;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, redirect_f;
  logic mem_wait;

  assign mem_wait = MemReqM & ~MemReadyM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      ret   <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret;
    cnt_nxt    = cnt;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    redirect_f = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          state_nxt = MEM_WAIT;
          ret_nxt   = RUN;
        end else if (BranchD) begin
          stall_f   = 1'b1;
          state_nxt = BR_WAIT;
          cnt_nxt   = BR_LOAD;
        end else if (LoadUseHazD) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      BR_WAIT: begin
        // A memory wait pre-empts resolution; cnt is left untouched so the
        // branch picks up where it was once the wait clears.
        if (mem_wait) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          state_nxt = MEM_WAIT;
          ret_nxt   = BR_WAIT;
        end else if (cnt != '0) begin
          stall_f = 1'b1;
          flush_d = 1'b1;
          cnt_nxt = cnt - 1'b1;
        end else begin
          flush_d    = 1'b1;
          redirect_f = BranchTakenE;
          state_nxt  = RUN;
        end
      end
      MEM_WAIT: begin
        if (!MemReadyM) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        end else begin
          state_nxt = ret;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are forced low for the whole reset interval, independent of clk.
  assign StallF    = rst_n & stall_f;
  assign StallD    = rst_n & stall_d;
  assign StallE    = rst_n & stall_e;
  assign StallM    = rst_n & stall_m;
  assign FlushD    = rst_n & flush_d;
  assign FlushE    = rst_n & flush_e;
  assign RedirectF = rst_n & redirect_f;
  assign CtrlState = state;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (StallF),
    .count (StallCount)
  );

endmodule
